// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand write modes and default datapath sizes.
package calc_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_INCR  = 2'b11
    } wrMode_e;

endpackage

// File: rtl/operand_reg_slice.sv
// One operand register with its valid and sticky overflow flags, updated by the
// selected write mode or by a bank-wide synchronous clear.
module operand_reg_slice
    import calc_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   incrSum;
    logic [WIDTH-1:0] shifted;

    assign incrSum = {1'b0, q_q} + (WIDTH+1)'(1);
    assign shifted = (q_q << DIGIT_W) | WIDTH'(data_i[DIGIT_W-1:0]);

    // Clear wins over any write; a SHIFT overflows when a nonzero top digit falls off.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            q_d     = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (we_i) begin
            case (mode_i)
                MODE_LOAD: begin
                    q_d     = data_i;
                    valid_d = 1'b1;
                    ovf_d   = 1'b0;
                end
                MODE_SHIFT: begin
                    q_d     = shifted;
                    valid_d = 1'b1;
                    ovf_d   = ovf_q | (q_q[WIDTH-1 -: DIGIT_W] != '0);
                end
                MODE_CLEAR: begin
                    q_d     = '0;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                default: begin
                    q_d   = incrSum[WIDTH-1:0];
                    ovf_d = ovf_q | incrSum[WIDTH];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q_o     = q_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/operand_reg_bank.sv
// Bank of operand registers with two combinational read ports; out-of-range
// indices are ignored on write and read back as zero.
module operand_reg_bank
    import calc_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NREGS   = 2,
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int SELW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [1:0]       wr_mode,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SELW-1:0]  rd_sel_a,
    input  logic [SELW-1:0]  rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [NREGS-1:0] valid,
    output logic [NREGS-1:0] ovf,
    output logic             all_valid
);

    logic [WIDTH-1:0] regQ [NREGS];

    for (genvar i = 0; i < NREGS; i++) begin : gSlice
        operand_reg_slice #(
            .WIDTH   (WIDTH),
            .DIGIT_W (DIGIT_W)
        ) uSlice (
            .clk     (clk),
            .reset   (reset),
            .clear_i (clear_all),
            .we_i    (wr_en && (wr_sel == SELW'(i))),
            .mode_i  (wr_mode),
            .data_i  (wr_data),
            .q_o     (regQ[i]),
            .valid_o (valid[i]),
            .ovf_o   (ovf[i])
        );
    end

    // Indices with no matching register leave the zero default in place.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_sel_a == SELW'(i)) rd_data_a = regQ[i];
            if (rd_sel_b == SELW'(i)) rd_data_b = regQ[i];
        end
    end

    assign all_valid = &valid;

endmodule
